apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB completer that terminates the bus driven by the AHB-to-APB bridge. It decodes one bit of the bridge's 3-bit `pselx`, holds a bank of 32-bit registers, and inserts a configurable number of wait states via `pready`. It flags illegal accesses on `pslverr`. It replaces the random-data read stub with real, checkable storage.

## Interface
- `SEL_BIT`, 0: index of the `pselx` bit that selects this block.
- `BASE_ADDR`, 32'h8000_0000: byte address of register 0.
- `NUM_REGS`, 16: number of 32-bit registers; power of two, 2..256.
- `WAIT_CYCLES`, 1: wait states inserted per transfer, 0..15.
- `ID_VALUE`, 32'hA9B0_0001: read-only contents of register 0.

Ports:
- `hclk` in 1: clock; all logic on its rising edge.
- `hreset` in 1: one clock; reset is synchronous and active-high.
- `pselx` in 3: APB selects; only `pselx[SEL_BIT]` is used.
- `penable` in 1: APB access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in 32: byte address.
- `pwdata` in 32: write data.
- `prdata` out 32: read data; registered.
- `pready` out 1: transfer completes this cycle; registered.
- `pslverr` out 1: error response, valid only while `pready`=1; registered.

## Operation
- Address decode uses `off = paddr - BASE_ADDR`, computed modulo 2^32.
- An address is valid when `off[1:0]==0` and `off>>2 < NUM_REGS`.
- Error conditions:
  - the address is not valid;
  - the transfer is a write to register 0.
- On error:
  - no register changes;
  - read data is 0.
- Register 0 always reads `ID_VALUE`. Registers 1..NUM_REGS-1 are read/write, full 32 bits, with no byte strobes.
- FSM states and transitions:
  - IDLE: `pready`=0. On `sel && !penable`, latch `pwrite`, the decoded index, `pwdata` and the error flag. Then go to WAIT if `WAIT_CYCLES`>0, else to DONE.
  - WAIT: the counter is loaded with `WAIT_CYCLES` on entry and decrements each cycle. When it reaches 1, go to DONE. If `sel` drops, abort to IDLE with no write.
  - DONE: `pready`=1 and `pslverr`=latched error. For a valid read, `prdata` = register value. For a write, the register updates at the clock edge ending DONE. Always return to IDLE.
- Control and data are taken only from the setup-phase latch. Changes to `paddr`, `pwrite` or `pwdata` during the access phase are ignored.
- Back-to-back transfers: a setup phase in the cycle after DONE is accepted from IDLE normally.
- `penable` seen in IDLE without a prior setup phase is a protocol violation. It is ignored and produces no `pready`.

## Timing
- Cycle numbering: T0 is the setup cycle (`sel`=1, `penable`=0); T1 is the first access cycle.
- `pready` is high exactly in cycle T1+`WAIT_CYCLES`, for exactly one cycle per transfer.
- `prdata` and `pslverr` are valid only in the `pready` cycle. At all other times they are 0.
- A write becomes visible to a read whose setup phase starts in the cycle after DONE.
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, FSM=IDLE, counter=0, registers 1..N-1 = 0.
- Reset asserted mid-transfer aborts it. No write occurs, and `pready` stays 0 from the next edge.

## Structure
- Shared package `apb_pkg`:
  - FSM state enum (IDLE, WAIT, DONE);
  - `APB_DW`=32 and `APB_AW`=32;
  - default `ID_VALUE` constant.
- One sub-module, `apb_addr_decode` (combinational): inputs `paddr` and `pwrite`; outputs register index and error flag. Parameterised by `BASE_ADDR` and `NUM_REGS`.
- The register bank is an array inside the top module.

## Test plan
- Reset, then read `BASE_ADDR` with `WAIT_CYCLES`=1 -> `pready` in T2, `prdata`=32'hA9B0_0001, `pslverr`=0.
- Write 32'hDEAD_BEEF to `BASE_ADDR`+4, then read it back-to-back -> each completes with `pready` in T2 of its own transfer; read returns 32'hDEAD_BEEF, `pslverr`=0.
- Write to `BASE_ADDR`+0x40 (NUM_REGS=16), to `BASE_ADDR`+2, and to `BASE_ADDR`+0 -> `pslverr`=1 each; all registers and the ID unchanged; reads of these error addresses return 0.
- `WAIT_CYCLES`=0 versus 3 -> `pready` in T1 versus T4; `prdata` is 0 outside the `pready` cycle.
- Drop `pselx[SEL_BIT]` during WAIT, and separately assert `hreset` in WAIT of a write of 32'h1234_5678 to `BASE_ADDR`+8 -> no `pready`; register 2 reads back 0.
- Drive `pselx`=3'b010 with `SEL_BIT`=0, and separately change `paddr`/`pwdata` during the access phase -> no response for the former; latched setup values used for the latter.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_pkg;

  localparam int unsigned APB_DW = 32;
  localparam int unsigned APB_AW = 32;

  localparam logic [APB_DW-1:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } apb_state_e;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational decode of an APB byte address into a register index and error flag.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       NUM_REGS  = 16,
  parameter int unsigned       IdxW      = $clog2(NUM_REGS)
) (
  input  logic [APB_AW-1:0] paddr,
  input  logic              pwrite,
  output logic [IdxW-1:0]   reg_idx,
  output logic              err
);

  logic [APB_AW-1:0] off;
  logic              valid;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  always_comb begin
    off     = paddr - BASE_ADDR;
    valid   = (off[1:0] == 2'b00) && ((off >> 2) < 32'(NUM_REGS));
    reg_idx = off[IdxW+1:2];
    err     = !valid || (pwrite && (reg_idx == '0));
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of 32-bit registers, fixed wait states and error response.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned       SEL_BIT     = 0,
  parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned       NUM_REGS    = 16,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [APB_DW-1:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [2:0]        pselx,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  output logic [APB_DW-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  logic sel;
  logic unused_pselx;
  assign sel          = pselx[SEL_BIT];
  assign unused_pselx = ^pselx;

  logic [IdxW-1:0] dec_idx;
  logic            dec_err;

  apb_addr_decode #(
    .BASE_ADDR(BASE_ADDR),
    .NUM_REGS (NUM_REGS),
    .IdxW     (IdxW)
  ) u_decode (
    .paddr  (paddr),
    .pwrite (pwrite),
    .reg_idx(dec_idx),
    .err    (dec_err)
  );

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [APB_DW-1:0] regs_q [NUM_REGS];
  logic [APB_DW-1:0] regs_d [NUM_REGS];
  logic [APB_DW-1:0] rd_val;

  // Next-state, setup-phase latch, register write and registered response.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    regs_d    = regs_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    rd_val    = '0;

    unique case (state_q)
      StIdle: begin
        if (sel && !penable) begin
          wr_d    = pwrite;
          idx_d   = dec_idx;
          wdata_d = pwdata;
          err_d   = dec_err;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            state_d = StDone;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (!sel) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (wr_q && !err_q) begin
          regs_d[idx_q] = wdata_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Response registers are loaded on the edge entering DONE so they are valid in that cycle.
    if (state_d == StDone) begin
      rd_val    = (idx_d == '0) ? ID_VALUE : regs_q[idx_d];
      pready_d  = 1'b1;
      pslverr_d = err_d;
      prdata_d  = (!err_d && !wr_d) ? rd_val : '0;
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: three instances with different select bits
// and wait-state counts, driven by a bus master task and checked by a monitor.
module tb_apb_slave_regfile;

  localparam logic [31:0] Base = 32'h8000_0000;
  localparam logic [31:0] Id   = 32'hA9B0_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic [2:0]  psel [3];
  logic        pen  [3];
  logic        pwr  [3];
  logic [31:0] padr [3];
  logic [31:0] pwd  [3];
  logic [31:0] prd  [3];
  logic        prdy [3];
  logic        perr [3];

  apb_slave_regfile #(.SEL_BIT(0), .WAIT_CYCLES(1)) u_dut0 (
    .hclk(clk), .hreset(rst[0]), .pselx(psel[0]), .penable(pen[0]), .pwrite(pwr[0]),
    .paddr(padr[0]), .pwdata(pwd[0]), .prdata(prd[0]), .pready(prdy[0]), .pslverr(perr[0])
  );
  apb_slave_regfile #(.SEL_BIT(1), .WAIT_CYCLES(0)) u_dut1 (
    .hclk(clk), .hreset(rst[1]), .pselx(psel[1]), .penable(pen[1]), .pwrite(pwr[1]),
    .paddr(padr[1]), .pwdata(pwd[1]), .prdata(prd[1]), .pready(prdy[1]), .pslverr(perr[1])
  );
  apb_slave_regfile #(.SEL_BIT(2), .WAIT_CYCLES(3)) u_dut2 (
    .hclk(clk), .hreset(rst[2]), .pselx(psel[2]), .penable(pen[2]), .pwrite(pwr[2]),
    .paddr(padr[2]), .pwdata(pwd[2]), .prdata(prd[2]), .pready(prdy[2]), .pslverr(perr[2])
  );

  typedef struct {
    int          d;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mem [3][16];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic logic [2:0] sel_of(input int d);
    logic [2:0] one;
    one = 3'b001;
    return one << d;
  endfunction

  // Response checker: pops the expected response on pready, otherwise requires quiet outputs.
  always @(negedge clk) begin : monitor
    exp_t x;
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (prdy[d] === 1'b1) begin
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pready dut%0d cyc %0d: got pready 1, want 0", d, cyc);
          end else begin
            x = sb.pop_front();
            if (x.d != d || x.cyc != cyc || prd[d] !== x.data || perr[d] !== x.err) begin
              errors++;
              $display("FAIL resp: got dut%0d cyc %0d data %h err %b, want dut%0d cyc %0d data %h err %b",
                       d, cyc, prd[d], perr[d], x.d, x.cyc, x.data, x.err);
            end
          end
        end else if (prdy[d] !== 1'b0 || prd[d] !== 32'h0 || perr[d] !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs dut%0d cyc %0d: got pready %b prdata %h pslverr %b, want 0 0 0",
                   d, cyc, prdy[d], prd[d], perr[d]);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        psel[d] = 3'b000;
        pen[d]  = 1'b0;
      end
    end
  endtask

  // One complete transfer; glitch scrambles control/data during the access phase.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] data,
                      input bit glitch);
    logic [31:0] off;
    bit          valid, e, got;
    int          idx;
    exp_t        x;
    off   = a - Base;
    valid = (off % 4 == 0) && (off / 4 < 16);
    idx   = valid ? int'(off / 4) : 0;
    e     = !valid || (w && idx == 0);
    x.d   = d;
    x.err = e;
    x.data = (e || w) ? 32'h0 : ((idx == 0) ? Id : mem[d][idx]);
    if (w && !e) mem[d][idx] = data;
    @(negedge clk);
    psel[d] = sel_of(d);
    pen[d]  = 1'b0;
    pwr[d]  = w;
    padr[d] = a;
    pwd[d]  = data;
    x.cyc   = cyc + 1 + wc(d);
    sb.push_back(x);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      pen[d] = 1'b1;
      if (glitch) begin
        padr[d] = ~a;
        pwd[d]  = ~data;
        pwr[d]  = !w;
      end
      if (prdy[d] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d addr %h: got no pready, want pready", d, a);
    end
  endtask

  // Starts a write and kills it during WAIT by dropping select (kill_rst=0) or by reset.
  task automatic aborted_write(input int d, input logic [31:0] a, input logic [31:0] data,
                               input bit kill_rst);
    @(negedge clk);
    psel[d] = sel_of(d);
    pen[d]  = 1'b0;
    pwr[d]  = 1'b1;
    padr[d] = a;
    pwd[d]  = data;
    @(negedge clk);
    pen[d] = 1'b1;
    @(negedge clk);
    if (kill_rst) begin
      rst[d] = 1'b1;
      for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
    end
    psel[d] = 3'b000;
    pen[d]  = 1'b0;
    @(negedge clk);
    rst[d] = 1'b0;
  endtask

  // Holds a fixed bus pattern that must never produce a response.
  task automatic no_xfer(input int d, input logic [2:0] s, input bit e, input int n);
    @(negedge clk);
    psel[d] = s;
    pen[d]  = e;
    pwr[d]  = 1'b1;
    padr[d] = Base + 32'h4;
    pwd[d]  = 32'hFFFF_0000;
    for (int i = 0; i < n; i++) @(negedge clk);
    psel[d] = 3'b000;
    pen[d]  = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    for (int i = 0; i < 3; i++) begin
      rst[i]  = 1'b1;
      psel[i] = 3'b000;
      pen[i]  = 1'b0;
      pwr[i]  = 1'b0;
      padr[i] = 32'h0;
      pwd[i]  = 32'h0;
      for (int j = 0; j < 16; j++) mem[i][j] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // ID read, then write and back-to-back readback.
    xfer(0, 1'b0, Base, 32'h0, 1'b0);
    xfer(0, 1'b1, Base + 32'h4, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b0, Base + 32'h4, 32'h0, 1'b0);

    // Error accesses leave state untouched.
    xfer(0, 1'b1, Base + 32'h40, 32'h1111_1111, 1'b0);
    xfer(0, 1'b1, Base + 32'h2, 32'h2222_2222, 1'b0);
    xfer(0, 1'b1, Base, 32'h3333_3333, 1'b0);
    xfer(0, 1'b0, Base + 32'h40, 32'h0, 1'b0);
    xfer(0, 1'b0, Base + 32'h2, 32'h0, 1'b0);
    xfer(0, 1'b0, Base, 32'h0, 1'b0);
    xfer(0, 1'b0, Base + 32'h4, 32'h0, 1'b0);
    xfer(0, 1'b0, Base - 32'h4, 32'h0, 1'b0);
    idle(2);

    // Zero and three wait states.
    xfer(1, 1'b1, Base + 32'hC, 32'hC0DE_0001, 1'b0);
    xfer(1, 1'b0, Base + 32'hC, 32'h0, 1'b0);
    xfer(1, 1'b0, Base, 32'h0, 1'b0);
    xfer(2, 1'b1, Base + 32'hC, 32'hC0DE_0003, 1'b0);
    xfer(2, 1'b0, Base + 32'hC, 32'h0, 1'b0);
    idle(2);

    // Aborts: select drop, then reset, both during WAIT.
    aborted_write(2, Base + 32'h8, 32'h1234_5678, 1'b0);
    idle(3);
    xfer(2, 1'b0, Base + 32'h8, 32'h0, 1'b0);
    aborted_write(2, Base + 32'h8, 32'h1234_5678, 1'b1);
    idle(3);
    xfer(2, 1'b0, Base + 32'h8, 32'h0, 1'b0);
    xfer(2, 1'b0, Base + 32'hC, 32'h0, 1'b0);
    idle(2);

    // Wrong select bit, and penable without setup.
    no_xfer(0, 3'b010, 1'b0, 6);
    no_xfer(0, 3'b001, 1'b1, 6);
    idle(2);
    xfer(0, 1'b0, Base + 32'h4, 32'h0, 1'b0);

    // Access-phase changes must be ignored.
    xfer(0, 1'b1, Base + 32'h14, 32'h0BAD_F00D, 1'b1);
    xfer(0, 1'b0, Base + 32'h14, 32'h0, 1'b1);
    xfer(1, 1'b1, Base + 32'h18, 32'h5A5A_A5A5, 1'b1);
    xfer(1, 1'b0, Base + 32'h18, 32'h0, 1'b0);
    idle(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      d = $urandom_range(0, 2);
      a = Base + 32'($urandom_range(0, 19)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = Base - 32'h4;
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: got %0d outstanding, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
